// File: rtl/stream_session_ctrl_pkg.sv
// Shared definitions for the producer-session controller: FSM encodings and sizing helpers.
package stream_session_ctrl_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/stream_session_ctrl_if.sv
// Session bus between the producer/consumer side (master) and the controller (slave).
interface stream_session_ctrl_if
  import stream_session_ctrl_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 16
);
  localparam int CW = max1(clog2(N));

  logic [N-1:0]  start;
  logic          stop;
  logic          buf_full;
  logic          buf_empty;
  logic          data_valid;
  logic [W-1:0]  data;
  logic [N-1:0]  en;
  logic [CW-1:0] chan;
  logic          busy;
  logic          drain_err;
  logic          parity;

  modport master (
    output start, stop, buf_full, buf_empty, data_valid, data,
    input  en, chan, busy, drain_err, parity
  );

  modport slave (
    input  start, stop, buf_full, buf_empty, data_valid, data,
    output en, chan, busy, drain_err, parity
  );

endinterface

// File: rtl/stream_session_ctrl_prio_enc_lsb.sv
// Lowest-index-wins priority encoder; masked bits never win.
module prio_enc_lsb #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_mask,
  output logic [IW-1:0] o_idx,
  output logic          o_vld
);

  logic [N-1:0] w_req;

  assign w_req = i_req & ~i_mask;
  assign o_vld = |w_req;

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_req[i]) o_idx = IW'(i);
    end
  end

endmodule

// File: rtl/stream_session_ctrl.sv
// N-channel producer session controller: grants one producer, pauses on backpressure,
// drains the CDC buffer on stop or channel switch, flags stuck drains, registers data parity.
module stream_session_ctrl
  import stream_session_ctrl_pkg::*;
#(
  parameter int N             = 2,
  parameter int W             = 16,
  parameter int ODD           = 0,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_session_ctrl_if.slave bus
);

  localparam int CW   = max1(clog2(N));
  localparam int CNTW = max1(clog2(DRAIN_TIMEOUT + 1));
  localparam logic [CNTW-1:0] TO_LAST = CNTW'((DRAIN_TIMEOUT == 0) ? 0 : DRAIN_TIMEOUT - 1);
  localparam bit TO_EN = (DRAIN_TIMEOUT != 0);

  logic [1:0]      r_state;
  logic [CW-1:0]   r_chan;
  logic [CW-1:0]   r_pend;
  logic            r_pend_v;
  logic [CNTW-1:0] r_cnt;
  logic            r_derr;
  logic            r_par;

  logic [N-1:0]    w_chan_mask;
  logic [CW-1:0]   w_any_idx;
  logic            w_any_v;
  logic [CW-1:0]   w_sw_idx;
  logic            w_sw_v;
  logic            w_exit;
  logic            w_to;

  always_comb begin
    w_chan_mask = '0;
    for (int i = 0; i < N; i++) w_chan_mask[i] = (r_chan == CW'(i));
  end

  prio_enc_lsb #(.N(N), .IW(CW)) u_any (
    .i_req  (bus.start),
    .i_mask ({N{1'b0}}),
    .o_idx  (w_any_idx),
    .o_vld  (w_any_v)
  );

  // Switch requests: any start other than the channel already granted.
  prio_enc_lsb #(.N(N), .IW(CW)) u_sw (
    .i_req  (bus.start),
    .i_mask (w_chan_mask),
    .o_idx  (w_sw_idx),
    .o_vld  (w_sw_v)
  );

  assign w_exit = bus.buf_empty & ~bus.data_valid;
  assign w_to   = TO_EN && (r_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_chan   <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_cnt    <= '0;
      r_derr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_v) begin
            r_state <= S_RUN;
            r_chan  <= w_any_idx;
            r_derr  <= 1'b0;
          end
        end
        S_RUN, S_WAIT: begin
          if (bus.stop) begin
            r_state  <= S_DRAIN;
            r_pend_v <= 1'b0;
            r_cnt    <= '0;
          end else if (w_sw_v) begin
            r_state  <= S_DRAIN;
            r_pend   <= w_sw_idx;
            r_pend_v <= 1'b1;
            r_cnt    <= '0;
          end else if (r_state == S_RUN && bus.buf_full) begin
            r_state <= S_WAIT;
          end else if (r_state == S_WAIT && !bus.buf_full) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          // A clean drain takes precedence over a timeout landing on the same cycle.
          if (w_exit) begin
            r_pend_v <= 1'b0;
            if (r_pend_v) begin
              r_state <= S_RUN;
              r_chan  <= r_pend;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (w_to) begin
            r_state  <= S_IDLE;
            r_derr   <= 1'b1;
            r_pend_v <= 1'b0;
          end else if (bus.stop) begin
            r_pend_v <= 1'b0;
          end else if (w_any_v) begin
            r_pend   <= w_any_idx;
            r_pend_v <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_par <= 1'b0;
    else      r_par <= (^bus.data) ^ 1'(ODD);
  end

  always_comb begin
    bus.en = '0;
    for (int i = 0; i < N; i++) bus.en[i] = (r_state == S_RUN) && (r_chan == CW'(i));
  end

  assign bus.chan      = r_chan;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.drain_err = r_derr;
  assign bus.parity    = r_par;

endmodule

// File: doc/stream_session_ctrl.md
Name: stream_session_ctrl

Overview:
- N-channel generalisation of the producer-session controller.
- Grants one of N producers (fibonacci, timer, future sources) an enable, pauses it on buffer backpressure and drains the CDC buffer on stop.
- Supports switching channels mid-session through an automatic drain-then-restart.
- Flags a drain that never completes (timeout) and outputs registered even/odd parity of the consumer-side data word.

Parameters:
N, 2, number of producer channels (1..16)
W, 16, consumer data word width
ODD, 0, 0 = even parity (XOR of bits), 1 = odd parity (inverted XOR)
DRAIN_TIMEOUT, 1024, max cycles in DRAIN before abort; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low (asserted when 0)
start  in  N  per-channel start request, one-cycle pulse (already edge-detected)
stop  in  1  stop request, one-cycle pulse
buf_full  in  1  CDC buffer full
buf_empty  in  1  CDC buffer empty
data_valid  in  1  consumer output register holds valid data
data  in  W  consumer output word
en  out  N  one-hot producer enable
chan  out  CW  index of current/last channel, CW = max(1, clog2(N))
busy  out  1  state != IDLE
drain_err  out  1  sticky drain-timeout flag
parity  out  1  registered parity of data

Behaviour:
- Reset (rst=0), asynchronous: state=IDLE, chan=0, pending_v=0, pending=0, drain counter=0, drain_err=0, parity=0.
- Outputs are decoded only from registers. en[chan]=1 only in RUN; en=0 in IDLE, WAIT and DRAIN. busy=1 in RUN, WAIT and DRAIN.
- Priority: within a set of start bits, the lowest index wins. stop outranks start, and start outranks buf_full.
- A "switch start" is any start bit other than bit chan.

State machine (4 states, 2-bit):
- IDLE:
  - stop ignored.
  - Any start bit -> RUN next cycle; chan <= lowest set index; drain_err <= 0.
  - en[chan] goes high 1 cycle after the start pulse.
- RUN:
  - stop -> DRAIN; pending_v <= 0.
  - Else switch start -> DRAIN; pending <= lowest set index ≠ chan; pending_v <= 1.
  - Else buf_full -> WAIT.
  - start on the current channel alone is ignored.
- WAIT:
  - stop -> DRAIN; switch start handled as in RUN.
  - Else !buf_full -> RUN; en re-asserts 1 cycle after buf_full falls.
- DRAIN:
  - Counter cleared on entry, increments each cycle.
  - Exit condition buf_empty && !data_valid:
    - pending_v=1 -> RUN with chan <= pending, pending_v <= 0.
    - Else -> IDLE.
  - Timeout: DRAIN_TIMEOUT≠0 and counter == DRAIN_TIMEOUT-1 without the exit condition -> IDLE; drain_err <= 1; pending_v <= 0.
  - If the exit condition and timeout coincide, the exit condition wins and drain_err is not set.
  - stop in DRAIN clears pending_v.
  - Any start bit in DRAIN overwrites pending with the lowest set index (including the current chan) and sets pending_v.
- Counter width is clog2(DRAIN_TIMEOUT+1). It saturates and does not wrap.

Parity:
- parity <= (^data) ^ ODD every cycle, independent of state and data_valid.
- Latency 1 cycle.

Mid-operation reset: any state returns to IDLE immediately with en=0, with no drain.

Decomposition:
- Shared package: state encodings (S_IDLE=0, S_RUN=1, S_WAIT=2, S_DRAIN=3) and a clog2 helper function, reused by the top level.
- One sub-module, prio_enc_lsb: N-bit lowest-index priority encoder with a mask input (used to exclude chan). Outputs index and valid.

Test Plan:
Use N=4, W=16, DRAIN_TIMEOUT=8.
1. Reset release, pulse start=4'b0110 -> next cycle state RUN, chan=1, en=4'b0010, busy=1.
2. In RUN, buf_full=1 for 3 cycles then 0 -> en=0 during WAIT; en=4'b0010 again 1 cycle after buf_full falls.
3. In RUN chan=1, pulse start=4'b1000 -> DRAIN with en=0. Hold buf_empty=0 for 3 cycles, then buf_empty=1, data_valid=0 -> RUN with chan=3, en=4'b1000, drain_err=0.
4. stop and start=4'b0001 in the same RUN cycle -> DRAIN with pending_v=0; on empty -> IDLE, busy=0.
5. In DRAIN hold buf_empty=0 -> exactly 8 cycles after entry, IDLE and drain_err=1. Next start=4'b0001 -> drain_err=0, chan=0.
6. data=16'h0007 with ODD=0 -> parity=1 one cycle later. data=16'h0003 -> parity=0. Assert rst=0 mid-RUN -> en=0 and parity=0 immediately, without waiting for a clock edge.
